// File: rtl/rtc_pkg.sv
// Shared RTC constants: sequencer states, register addresses, command codes and BCD limits.
package rtc_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned FIELD_N = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEG,
      ST_MIN,
      ST_HORA,
      ST_DIA,
      ST_MES,
      ST_ANO,
      ST_COMMIT
   } rtc_wr_state_e;

   typedef enum logic [2:0] {
      FLD_SEC,
      FLD_MIN,
      FLD_HOUR,
      FLD_DAY,
      FLD_MONTH,
      FLD_YEAR
   } rtc_field_e;

   localparam logic [BYTE_W-1:0] ADDR_DIA     = 8'h24;
   localparam logic [BYTE_W-1:0] ADDR_MES     = 8'h25;
   localparam logic [BYTE_W-1:0] ADDR_ANO     = 8'h26;
   localparam logic [BYTE_W-1:0] ADDR_CMD_CLK = 8'hF1;
   localparam logic [BYTE_W-1:0] ADDR_CMD_TMR = 8'hF2;
   localparam logic [BYTE_W-1:0] CMD_COMMIT   = 8'h02;
   localparam logic [BYTE_W-1:0] DIR_IDLE     = 8'hFF;

   localparam logic [3:0]        BCD_MAX_NIBBLE = 4'h9;
   localparam logic [BYTE_W-1:0] BCD_MAX_SEC    = 8'h59;
   localparam logic [BYTE_W-1:0] BCD_MAX_MIN    = 8'h59;
   localparam logic [BYTE_W-1:0] BCD_MAX_HORA   = 8'h23;
   localparam logic [BYTE_W-1:0] BCD_MIN_DIA    = 8'h01;
   localparam logic [BYTE_W-1:0] BCD_MAX_DIA    = 8'h31;
   localparam logic [BYTE_W-1:0] BCD_MIN_MES    = 8'h01;
   localparam logic [BYTE_W-1:0] BCD_MAX_MES    = 8'h12;

   function automatic logic bcd_nibbles_ok(input logic [BYTE_W-1:0] v);
      return (v[7:4] <= BCD_MAX_NIBBLE) && (v[3:0] <= BCD_MAX_NIBBLE);
   endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// Combinational BCD range check for one time/date field; out-of-range values are
// replaced by the field's safe default (0x01 for day/month, 0x00 otherwise).
module rtc_bcd_check
   import rtc_pkg::*;
(
   input  logic [BYTE_W-1:0] value_i,
   input  rtc_field_e        field_i,
   output logic [BYTE_W-1:0] fixed_o,
   output logic              err_o
);

   logic              bad;
   logic [BYTE_W-1:0] repl;

   always_comb begin
      bad  = !bcd_nibbles_ok(value_i);
      repl = 8'h00;
      case (field_i)
         FLD_SEC:   bad = bad | (value_i > BCD_MAX_SEC);
         FLD_MIN:   bad = bad | (value_i > BCD_MAX_MIN);
         FLD_HOUR:  bad = bad | (value_i > BCD_MAX_HORA);
         FLD_DAY: begin
            bad  = bad | (value_i < BCD_MIN_DIA) | (value_i > BCD_MAX_DIA);
            repl = BCD_MIN_DIA;
         end
         FLD_MONTH: begin
            bad  = bad | (value_i < BCD_MIN_MES) | (value_i > BCD_MAX_MES);
            repl = BCD_MIN_MES;
         end
         default: ;
      endcase
      fixed_o = bad ? repl : value_i;
      err_o   = bad;
   end

endmodule

// File: rtl/rtc_write_sequencer.sv
// RTC write sequencer: snapshots time/date, writes each field over the DIR/DAT bus, then commits.
// Optional BCD range checking of captured values when RTC_WRITE_BCD_CHECK_EN is defined.
module rtc_write_sequencer
   import rtc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              Escritura,
   input  logic              En_clk,
   input  logic              DIR,
   input  logic              DAT,
   input  logic              cambio_estado,
   input  logic [BYTE_W-1:0] D_Seg,
   input  logic [BYTE_W-1:0] D_Min,
   input  logic [BYTE_W-1:0] D_Hora,
   input  logic [BYTE_W-1:0] Seg_E,
   input  logic [BYTE_W-1:0] Min_E,
   input  logic [BYTE_W-1:0] Hora_E,
   input  logic [BYTE_W-1:0] Dia_E,
   input  logic [BYTE_W-1:0] Mes_E,
   input  logic [BYTE_W-1:0] Ano_E,
   output logic [BYTE_W-1:0] Dir_E,
   output logic              E_Esc,
   output logic              Tr_Esc,
   output logic              Term_Esc,
   output logic              Err_Esc
);

   rtc_wr_state_e     state_q, state_d;
   logic [BYTE_W-1:0] dir_q, dir_d;
   logic              e_q, e_d;
   logic              tr_q, tr_d;
   logic              err_q, err_d;
   logic              mode_q, mode_d;
   logic              start;
   logic              term;
   logic [BYTE_W-1:0] fld_addr, fld_data;
   rtc_wr_state_e     fld_next;

   logic [BYTE_W-1:0] raw_val [FIELD_N];
   logic [BYTE_W-1:0] cap_val [FIELD_N];
   logic [BYTE_W-1:0] sh_q    [FIELD_N];
   logic [FIELD_N-1:0] cap_err;

   assign raw_val[0] = Seg_E;
   assign raw_val[1] = Min_E;
   assign raw_val[2] = Hora_E;
   assign raw_val[3] = Dia_E;
   assign raw_val[4] = Mes_E;
   assign raw_val[5] = Ano_E;

`ifdef RTC_WRITE_BCD_CHECK_EN
   for (genvar i = 0; i < FIELD_N; i++) begin : g_chk
      rtc_bcd_check u_chk (
         .value_i (raw_val[i]),
         .field_i (rtc_field_e'(3'(i))),
         .fixed_o (cap_val[i]),
         .err_o   (cap_err[i])
      );
   end
`else
   assign cap_val = raw_val;
   assign cap_err = '0;
`endif

   // Per-state bus address, data byte and successor state.
   always_comb begin
      fld_addr = DIR_IDLE;
      fld_data = DIR_IDLE;
      fld_next = ST_IDLE;
      case (state_q)
         ST_SEG:    begin fld_addr = D_Seg;    fld_data = sh_q[0]; fld_next = ST_MIN;  end
         ST_MIN:    begin fld_addr = D_Min;    fld_data = sh_q[1]; fld_next = ST_HORA; end
         ST_HORA:   begin
            fld_addr = D_Hora;
            fld_data = sh_q[2];
            fld_next = mode_q ? ST_DIA : ST_COMMIT;
         end
         ST_DIA:    begin fld_addr = ADDR_DIA; fld_data = sh_q[3]; fld_next = ST_MES;    end
         ST_MES:    begin fld_addr = ADDR_MES; fld_data = sh_q[4]; fld_next = ST_ANO;    end
         ST_ANO:    begin fld_addr = ADDR_ANO; fld_data = sh_q[5]; fld_next = ST_COMMIT; end
         ST_COMMIT: begin
            fld_addr = mode_q ? ADDR_CMD_CLK : ADDR_CMD_TMR;
            fld_data = CMD_COMMIT;
            fld_next = ST_IDLE;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      e_d     = e_q;
      tr_d    = tr_q;
      err_d   = err_q;
      mode_d  = mode_q;
      start   = 1'b0;
      term    = 1'b0;
      if (state_q == ST_IDLE) begin
         dir_d = DIR_IDLE;
         e_d   = 1'b0;
         tr_d  = 1'b0;
         if (Escritura) begin
            start   = 1'b1;
            state_d = ST_SEG;
            e_d     = 1'b1;
            err_d   = |cap_err;
            mode_d  = En_clk;
         end
      end else begin
         e_d = 1'b1;
         if (DIR) begin
            dir_d = fld_addr;
         end else if (DAT) begin
            dir_d = fld_data;
            if (state_q == ST_COMMIT) tr_d = 1'b1;
         end else if (cambio_estado) begin
            e_d     = 1'b0;
            state_d = fld_next;
            if (state_q == ST_COMMIT) begin
               tr_d  = 1'b0;
               term  = 1'b1;
               dir_d = DIR_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_IDLE;
         e_q     <= 1'b0;
         tr_q    <= 1'b0;
         err_q   <= 1'b0;
         mode_q  <= 1'b0;
         for (int i = 0; i < FIELD_N; i++) sh_q[i] <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         e_q     <= e_d;
         tr_q    <= tr_d;
         err_q   <= err_d;
         mode_q  <= mode_d;
         if (start) begin
            for (int i = 0; i < FIELD_N; i++) sh_q[i] <= cap_val[i];
         end
      end
   end

   assign Dir_E    = dir_q;
   assign E_Esc    = e_q;
   assign Tr_Esc   = tr_q;
   assign Err_Esc  = err_q;
   // Completion pulse is suppressed while reset is asserted.
   assign Term_Esc = term & reset;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Scoreboard bench for rtc_write_sequencer: expected bus bytes are queued by the driver and
// checked by a monitor after every DIR/DAT phase.
module tb_rtc_write_sequencer;

   logic       clk = 1'b0;
   logic       reset, Escritura, En_clk, DIR, DAT, cambio_estado;
   logic [7:0] D_Seg, D_Min, D_Hora;
   logic [7:0] Seg_E, Min_E, Hora_E, Dia_E, Mes_E, Ano_E;
   logic [7:0] Dir_E;
   logic       E_Esc, Tr_Esc, Term_Esc, Err_Esc;

   int         checks = 0;
   int         errors = 0;
   int         term_cnt = 0;
   int         t0;
   logic       strb_seen = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_min;
   logic       exp_err;

   always #5 clk = ~clk;

   rtc_write_sequencer dut (
      .clk(clk), .reset(reset), .Escritura(Escritura), .En_clk(En_clk),
      .DIR(DIR), .DAT(DAT), .cambio_estado(cambio_estado),
      .D_Seg(D_Seg), .D_Min(D_Min), .D_Hora(D_Hora),
      .Seg_E(Seg_E), .Min_E(Min_E), .Hora_E(Hora_E),
      .Dia_E(Dia_E), .Mes_E(Mes_E), .Ano_E(Ano_E),
      .Dir_E(Dir_E), .E_Esc(E_Esc), .Tr_Esc(Tr_Esc),
      .Term_Esc(Term_Esc), .Err_Esc(Err_Esc)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every bus phase sampled at a rising edge must produce the next queued byte.
   always @(posedge clk) strb_seen <= reset & (DIR | DAT);

   always @(negedge clk) begin
      if (Term_Esc) term_cnt++;
      if (strb_seen) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dir_e_unexpected: got %h expected no phase at %0t", Dir_E, $time);
         end else begin
            chk("dir_e", Dir_E, exp_q.pop_front());
         end
      end
   end

   // Entered and left at 1 time unit after a rising edge.
   task automatic drive(input logic d, input logic t, input logic c);
      DIR = d; DAT = t; cambio_estado = c;
      @(posedge clk); #1;
      DIR = 1'b0; DAT = 1'b0; cambio_estado = 1'b0;
   endtask

   task automatic field(input logic [7:0] a, input logic [7:0] v);
      exp_q.push_back(a);
      drive(1'b1, 1'b0, 1'b0);
      exp_q.push_back(v);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
   endtask

   task automatic start_seq();
      Escritura = 1'b1;
      @(posedge clk); #1;
      Escritura = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; Escritura = 1'b0; En_clk = 1'b1;
      DIR = 1'b0; DAT = 1'b0; cambio_estado = 1'b0;
      D_Seg = 8'h21; D_Min = 8'h22; D_Hora = 8'h23;
      Seg_E = 8'h45; Min_E = 8'h30; Hora_E = 8'h12;
      Dia_E = 8'h15; Mes_E = 8'h09; Ano_E = 8'h16;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      chk("rst_dir_e", Dir_E, 8'hFF);
      chk1("rst_e_esc", E_Esc, 1'b0);
      chk1("rst_tr_esc", Tr_Esc, 1'b0);
      chk1("rst_term_esc", Term_Esc, 1'b0);
      chk1("rst_err_esc", Err_Esc, 1'b0);

      // Clock write; Seg_E changes after capture and a stray request arrives mid-sequence.
      start_seq();
      chk1("start_e_esc", E_Esc, 1'b1);
      Seg_E = 8'h10;
      Escritura = 1'b1;
      field(8'h21, 8'h45);
      Escritura = 1'b0;
      chk1("gap_e_esc", E_Esc, 1'b0);
      field(8'h22, 8'h30);
      field(8'h23, 8'h12);
      field(8'h24, 8'h15);
      field(8'h25, 8'h09);
      field(8'h26, 8'h16);
      exp_q.push_back(8'hF1);
      drive(1'b1, 1'b0, 1'b0);
      chk1("commit_tr_low", Tr_Esc, 1'b0);
      exp_q.push_back(8'h02);
      drive(1'b0, 1'b1, 1'b0);
      chk1("commit_tr_high", Tr_Esc, 1'b1);
      t0 = term_cnt;
      drive(1'b0, 1'b0, 1'b1);
      chk("clk_term_once", 8'(term_cnt - t0), 8'd1);
      chk1("end_tr_esc", Tr_Esc, 1'b0);
      chk1("end_e_esc", E_Esc, 1'b0);
      chk("end_dir_e", Dir_E, 8'hFF);
      chk1("clk_err_esc", Err_Esc, 1'b0);

      // Timer write; En_clk toggles after start and must be ignored.
      En_clk = 1'b0;
      D_Seg = 8'h41; D_Min = 8'h42; D_Hora = 8'h43;
      Seg_E = 8'h05; Min_E = 8'h10; Hora_E = 8'h02;
      start_seq();
      En_clk = 1'b1;
      field(8'h41, 8'h05);
      field(8'h42, 8'h10);
      field(8'h43, 8'h02);
      exp_q.push_back(8'hF2);
      drive(1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'h02);
      drive(1'b0, 1'b1, 1'b0);
      // Request coinciding with completion is dropped, then taken the next cycle.
      Seg_E = 8'h33; Min_E = 8'h44; Hora_E = 8'h07; Dia_E = 8'h28;
      t0 = term_cnt;
      Escritura = 1'b1;
      drive(1'b0, 1'b0, 1'b1);
      chk("tmr_term_once", 8'(term_cnt - t0), 8'd1);
      chk1("same_cycle_req_ignored", E_Esc, 1'b0);
      @(posedge clk); #1;
      Escritura = 1'b0;
      chk1("next_cycle_req_taken", E_Esc, 1'b1);

      // DIR and DAT together in MIN: address wins, no advance; reset during MES.
      field(8'h41, 8'h33);
      exp_q.push_back(8'h42);
      drive(1'b1, 1'b1, 1'b0);
      chk1("dirdat_e_esc", E_Esc, 1'b1);
      exp_q.push_back(8'h44);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      field(8'h43, 8'h07);
      field(8'h24, 8'h28);
      exp_q.push_back(8'h25);
      drive(1'b1, 1'b0, 1'b0);
      t0 = term_cnt;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      chk("rst_mid_dir_e", Dir_E, 8'hFF);
      chk1("rst_mid_e_esc", E_Esc, 1'b0);
      chk1("rst_mid_tr_esc", Tr_Esc, 1'b0);
      chk("rst_mid_no_term", 8'(term_cnt - t0), 8'd0);

      // Out-of-range minutes value.
`ifdef RTC_WRITE_BCD_CHECK_EN
      exp_min = 8'h00; exp_err = 1'b1;
`else
      exp_min = 8'h7A; exp_err = 1'b0;
`endif
      En_clk = 1'b0;
      Seg_E = 8'h59; Min_E = 8'h7A; Hora_E = 8'h23;
      start_seq();
      chk1("bcd_err_set", Err_Esc, exp_err);
      field(8'h41, 8'h59);
      field(8'h42, exp_min);
      field(8'h43, 8'h23);
      exp_q.push_back(8'hF2);
      drive(1'b1, 1'b0, 1'b0);
      exp_q.push_back(8'h02);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      chk1("bcd_err_held", Err_Esc, exp_err);
      Min_E = 8'h30;
      start_seq();
      chk1("bcd_err_cleared", Err_Esc, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;

      @(negedge clk);
      chk("sb_empty", 8'(exp_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_write_sequencer.md
# rtc_write_sequencer

Write-direction counterpart of the RTC read sequencer. On a start request it snapshots time and date values and walks the RTC bus register by register: seconds, minutes, hours, then day, month and year (clock mode only). It finishes with the commit/transfer command that moves RAM contents into the RTC counters. It sits beside the read sequencer under the main control FSM and shares the same DIR/DAT/cambio_estado bus-phase strobes.

## Interface
Parameters:
- none. All addresses and command codes are package constants.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- Escritura  in  1  start request; sampled only in IDLE
- En_clk  in  1  1 = clock target (6 fields), 0 = timer target (3 fields)
- DIR  in  1  bus address phase strobe
- DAT  in  1  bus data phase strobe
- cambio_estado  in  1  current bus transaction complete; advance
- D_Seg, D_Min, D_Hora  in  8  register addresses for sec/min/hour, supplied by the main FSM (clock or timer bank)
- Seg_E, Min_E, Hora_E, Dia_E, Mes_E, Ano_E  in  8 each  BCD values to write
- Dir_E  out  8  byte driven onto the bus: address during DIR, data during DAT
- E_Esc  out  1  bus-cycle enable, high while a field transaction is pending
- Tr_Esc  out  1  high from the commit-command data phase until its cambio_estado
- Term_Esc  out  1  one-cycle pulse when the sequence completes
- Err_Esc  out  1  sticky BCD error flag (see Configuration)

## Operation
- States: IDLE, SEG, MIN, HORA, DIA, MES, ANO, COMMIT.
- IDLE: Dir_E = 0xFF, E_Esc = 0. When Escritura = 1:
  - capture all six value inputs into shadow registers;
  - clear Err_Esc;
  - go to SEG with E_Esc = 1.
- Each field state applies one priority rule: DIR > DAT > cambio_estado.
  - DIR: Dir_E <= field address (D_Seg, D_Min, D_Hora, or ADDR_DIA 0x24, ADDR_MES 0x25, ADDR_ANO 0x26).
  - DAT: Dir_E <= shadow value of that field.
  - cambio_estado: go to the next state; E_Esc <= 0 for one cycle, then back to 1 in the new state.
  - None of the three: hold state and Dir_E.
- After HORA:
  - En_clk = 1: DIA, MES, ANO, then COMMIT.
  - En_clk = 0: straight to COMMIT.
  - En_clk is latched at start; later changes are ignored.
- COMMIT:
  - DIR: Dir_E <= 0xF1 (clock) or 0xF2 (timer).
  - DAT: Dir_E <= CMD_COMMIT 0x02 and Tr_Esc <= 1.
  - cambio_estado: Tr_Esc <= 0, E_Esc <= 0, Term_Esc = 1 for one cycle, return to IDLE.
- Escritura outside IDLE is ignored. A new request in the same cycle as Term_Esc is ignored; it is accepted from the next cycle.
- Reset mid-sequence: return to IDLE immediately. No Term_Esc pulse, Tr_Esc cleared.

## Timing
- All outputs are registered, except Term_Esc, which is combinational from state and cambio_estado (pulse in the completing cycle).
- Reset values: Dir_E 0xFF, E_Esc 0, Tr_Esc 0, Term_Esc 0, Err_Esc 0, state IDLE, shadows 0x00.
- Escritura sampled high at edge N gives E_Esc = 1 after edge N.
- DIR/DAT high at edge N gives the new Dir_E after edge N (1-cycle latency).
- Each field takes a minimum of 3 cycles (DIR, DAT, cambio_estado).
- Full clock sequence: at least 22 cycles from start to Term_Esc. Timer sequence: at least 13 cycles.

## Configuration
- RTC_WRITE_BCD_CHECK_EN defined:
  - each shadow value is checked at capture: nibbles ≤ 9, sec/min ≤ 0x59, hora ≤ 0x23, dia 0x01–0x31, mes 0x01–0x12;
  - an out-of-range field is replaced by 0x00 (dia/mes by 0x01);
  - Err_Esc is set and held until the next start.
- Not defined: values pass through unchanged and Err_Esc is tied to 0.

## Structure
- Shared package rtc_pkg holds:
  - state enum;
  - ADDR_DIA/MES/ANO;
  - ADDR_CMD_CLK 0xF1 and ADDR_CMD_TMR 0xF2;
  - CMD_COMMIT;
  - DIR_IDLE 0xFF;
  - BCD limit constants (shared with the read side).
- One sub-module, rtc_bcd_check: combinational range checker with inputs value and field type, outputs fixed value and error. It is instantiated six times and only under the macro.

## Test plan
- Clock write: En_clk = 1, values 0x45/0x30/0x12/0x15/0x09/0x16, DIR/DAT/cambio per field.
  - Dir_E sequence: D_Seg, 0x45, D_Min, 0x30, D_Hora, 0x12, 0x24, 0x15, 0x25, 0x09, 0x26, 0x16, 0xF1, 0x02.
  - Term_Esc pulses once.
- Timer write: En_clk = 0. After the HORA cambio the next DIR gives Dir_E = 0xF2. No 0x24–0x26 ever appears.
- Input change mid-sequence: Seg_E changes 0x45→0x10 after start. The DAT in SEG still drives 0x45.
- DIR and DAT high together in MIN: Dir_E = D_Min and the state does not advance.
- Reset low during MES: next cycle Dir_E = 0xFF, E_Esc = 0, no Term_Esc.
- With RTC_WRITE_BCD_CHECK_EN: Min_E = 0x7A. Data phase drives 0x00 and Err_Esc = 1 until the next Escritura.
